// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends an L-bit pattern MSB-first, repeated rep+1 times
// with a one-cycle gap between passes, and pulses done at the end of the transfer.
module serial_pattern_tx #(
    parameter int unsigned N = 8
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         start,
    input  logic [N-1:0] data,
    input  logic [3:0]   len,
    input  logic [1:0]   rep,
    output logic         w,
    output logic         valid,
    output logic         busy,
    output logic         done
);

    localparam int unsigned LW = 4;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10
    } state_t;

    state_t        state;
    logic [N-1:0]  sr;
    logic [N-1:0]  pat;
    logic [CW-1:0] bitcnt;
    logic [CW-1:0] lm1;
    logic [1:0]    passcnt;

    logic [LW-1:0] eff_len_c;
    logic [N-1:0]  aligned_c;
    logic [CW-1:0] lm1_c;
    logic [N-1:0]  sr_next_c;

    // Length 0 or anything beyond N means a full-width pattern; left-align it so bit L-1 leads.
    always_comb begin
        eff_len_c = len;
        if (len == '0 || 32'(len) > N) begin
            eff_len_c = LW'(N);
        end
        aligned_c = data << (LW'(N) - eff_len_c);
        lm1_c     = CW'(eff_len_c - LW'(1));
        sr_next_c = sr << 1;
    end

    // Outputs are loaded one edge ahead with the bit the next cycle will carry.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            sr      <= '0;
            pat     <= '0;
            bitcnt  <= '0;
            lm1     <= '0;
            passcnt <= '0;
            w       <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    w     <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        sr      <= aligned_c;
                        pat     <= aligned_c;
                        bitcnt  <= lm1_c;
                        lm1     <= lm1_c;
                        passcnt <= rep;
                        state   <= SEND;
                        w       <= aligned_c[N-1];
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                SEND: begin
                    sr <= sr_next_c;
                    if (bitcnt != '0) begin
                        bitcnt <= bitcnt - CW'(1);
                        w      <= sr_next_c[N-1];
                        valid  <= 1'b1;
                        busy   <= 1'b1;
                    end else if (passcnt != 2'd0) begin
                        state <= GAP;
                        w     <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        w     <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                GAP: begin
                    sr      <= pat;
                    bitcnt  <= lm1;
                    passcnt <= passcnt - 2'd1;
                    state   <= SEND;
                    w       <= pat[N-1];
                    valid   <= 1'b1;
                    busy    <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    w     <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: per-cycle {w,valid,busy,done} against hand-derived streams.
module tb_serial_pattern_tx;

    logic       Clock;
    logic       Resetn;
    logic       start;
    logic [7:0] data;
    logic [3:0] len;
    logic [1:0] rep;
    logic       w;
    logic       valid;
    logic       busy;
    logic       done;

    int total;
    int passed;

    serial_pattern_tx #(.N(8)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .start  (start),
        .data   (data),
        .len    (len),
        .rep    (rep),
        .w      (w),
        .valid  (valid),
        .busy   (busy),
        .done   (done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {w, valid, busy, done};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: {w,valid,busy,done} observed %b required %b", tag, obs, exp);
    endtask

    task automatic launch(input logic [7:0] d, input logic [3:0] l, input logic [1:0] r);
        data  = d;
        len   = l;
        rep   = r;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Expected streams are written MSB-first: bit n-1 is the first cycle after the start edge.
    task automatic expect_seq(input string tag, input int n, input logic [31:0] wv,
                              input logic [31:0] vv, input logic [31:0] bv, input logic [31:0] dv);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[c%0d]", tag, i + 1),
                  {wv[n-1-i], vv[n-1-i], bv[n-1-i], dv[n-1-i]});
            tick();
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        Resetn = 1'b0;
        start  = 1'b0;
        data   = '0;
        len    = '0;
        rep    = '0;

        #1;
        check("reset_t0", 4'b0000);
        tick();
        tick();
        check("reset_held", 4'b0000);
        #2 Resetn = 1'b1;
        tick();
        check("idle_after_reset", 4'b0000);

        launch(8'h0B, 4'd4, 2'd0);
        expect_seq("len4_0B", 5, 32'b10110, 32'b11110, 32'b11110, 32'b00001);
        check("idle_after_len4", 4'b0000);

        launch(8'hA5, 4'd0, 2'd0);
        expect_seq("len0_A5", 9, 32'b101001010, 32'b111111110, 32'b111111110, 32'b000000001);

        launch(8'h03, 4'd2, 2'd2);
        expect_seq("len2_rep2", 9, 32'b110110110, 32'b110110110, 32'b111111110, 32'b000000001);

        // Start re-asserted mid-transfer must be ignored; start in the done cycle is accepted.
        launch(8'h0B, 4'd4, 2'd0);
        check("ign_c1", 4'b1110);
        tick();
        check("ign_c2", 4'b0110);
        data  = 8'hFF;
        len   = 4'd8;
        rep   = 2'd3;
        start = 1'b1;
        tick();
        check("ign_c3", 4'b1110);
        tick();
        start = 1'b0;
        check("ign_c4", 4'b1110);
        tick();
        check("ign_c5_done", 4'b0001);
        launch(8'h02, 4'd2, 2'd0);
        expect_seq("b2b_len2", 3, 32'b100, 32'b110, 32'b110, 32'b001);

        launch(8'h01, 4'd1, 2'd3);
        expect_seq("len1_rep3", 8, 32'b10101010, 32'b10101010, 32'b11111110, 32'b00000001);

        launch(8'hA5, 4'd12, 2'd0);
        expect_seq("len12_A5", 9, 32'b101001010, 32'b111111110, 32'b111111110, 32'b000000001);

        // Asynchronous reset in cycle 2 of a full-length transfer.
        launch(8'hFF, 4'd8, 2'd1);
        check("rst_c1", 4'b1110);
        tick();
        check("rst_c2", 4'b1110);
        #3 Resetn = 1'b0;
        #1;
        check("rst_async_drop", 4'b0000);
        tick();
        check("rst_hold_1", 4'b0000);
        tick();
        check("rst_hold_2", 4'b0000);
        #2 Resetn = 1'b1;
        launch(8'h0B, 4'd4, 2'd0);
        expect_seq("post_rst_len4", 5, 32'b10110, 32'b11110, 32'b11110, 32'b00001);
        check("final_idle", 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
